// File: rtl/video_pkg.sv
// Shared video types: pixel word, frame counter width and scheduler FSM states.
package video_pkg;

  typedef logic [23:0] rgb24_t;

  localparam int FCNT_W = 16;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } sched_st_e;

endpackage

// File: rtl/rr_next_ready.sv
// Combinational round-robin finder: first ready index after sel, wrapping, excluding sel itself.
module rr_next_ready #(
  parameter int N_SRC = 4,
  localparam int SEL_W = $clog2(N_SRC)
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [N_SRC-1:0] src_ready,
  output logic [SEL_W-1:0] next_idx,
  output logic             found
);

  logic [SEL_W-1:0] cand_s;

  // Scan from the farthest offset down so the nearest ready source is the last one written.
  always_comb begin
    next_idx = sel;
    found    = 1'b0;
    cand_s   = sel;
    for (int k = N_SRC - 1; k >= 1; k--) begin
      cand_s   = SEL_W'((int'(sel) + k) % N_SRC);
      next_idx = src_ready[cand_s] ? cand_s : next_idx;
      found    = found | src_ready[cand_s];
    end
  end

endmodule

// File: rtl/video_src_sched.sv
// Frame-synchronous source scheduler in front of the DVI transmitter; timing and
// pixel are re-emitted with one cycle of latency.
module video_src_sched
  import video_pkg::*;
#(
  parameter int N_SRC          = 4,
  parameter int FRAMES_PER_SRC = 120,
  localparam int SEL_W         = $clog2(N_SRC)
) (
  input  logic                 clk_pix,
  input  logic                 rst_n,
  input  logic                 de_in,
  input  logic                 hs_in,
  input  logic                 vs_in,
  input  logic [24*N_SRC-1:0]  src_rgb,
  input  logic [N_SRC-1:0]     src_ready,
  input  logic                 auto_en,
  input  logic                 next_req,
  output logic                 next_ack,
  output logic [SEL_W-1:0]     sel,
  output logic                 de_out,
  output logic                 hs_out,
  output logic                 vs_out,
  output logic [23:0]          rgb_out,
  output logic                 switch_pulse
);

  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES_PER_SRC - 1);

  sched_st_e         st_q, st_d;
  logic              pend_q, pend_d;
  logic              next_ack_q, next_ack_d;
  logic              switch_pulse_q, switch_pulse_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              vs_q, de_q, hs_q;
  rgb24_t            rgb_q, rgb_d;

  logic              fs_s;
  logic              do_switch_s;
  logic [SEL_W-1:0]  rr_idx_s;
  logic              rr_found_s;

  rr_next_ready #(.N_SRC(N_SRC)) u_rr (
    .sel       (sel_q),
    .src_ready (src_ready),
    .next_idx  (rr_idx_s),
    .found     (rr_found_s)
  );

  // Next-state logic: frame-start detect, switch decision, handshake FSM and pixel mux.
  always_comb begin
    fs_s        = vs_in & ~vs_q;
    do_switch_s = fs_s & (pend_q | (auto_en & (fcnt_q == FCNT_LAST)));

    if (do_switch_s) begin
      fcnt_d = '0;
    end else if (fs_s) begin
      fcnt_d = fcnt_q + FCNT_W'(1);
    end else begin
      fcnt_d = fcnt_q;
    end

    // found already excludes the current index, so a hit always means a real change
    switch_pulse_d = do_switch_s & rr_found_s;
    sel_d          = switch_pulse_d ? rr_idx_s : sel_q;

    st_d   = st_q;
    pend_d = do_switch_s ? 1'b0 : pend_q;
    case (st_q)
      RUN: begin
        if (next_req) begin
          st_d   = PEND;
          pend_d = 1'b1;
        end else begin
          st_d = RUN;
        end
      end
      PEND: begin
        if (fs_s) begin
          st_d = ACK;
        end else begin
          st_d = PEND;
        end
      end
      ACK: begin
        if (!next_req) begin
          st_d = RUN;
        end else begin
          st_d = ACK;
        end
      end
      default: begin
        st_d   = RUN;
        pend_d = 1'b0;
      end
    endcase
    next_ack_d = (st_d == ACK);

    if (de_in && src_ready[sel_q]) begin
      rgb_d = src_rgb[24*sel_q +: 24];
    end else begin
      rgb_d = 24'h000000;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      st_q           <= RUN;
      pend_q         <= 1'b0;
      next_ack_q     <= 1'b0;
      switch_pulse_q <= 1'b0;
      sel_q          <= '0;
      fcnt_q         <= '0;
      vs_q           <= 1'b0;
      de_q           <= 1'b0;
      hs_q           <= 1'b0;
      rgb_q          <= 24'h000000;
    end else begin
      st_q           <= st_d;
      pend_q         <= pend_d;
      next_ack_q     <= next_ack_d;
      switch_pulse_q <= switch_pulse_d;
      sel_q          <= sel_d;
      fcnt_q         <= fcnt_d;
      vs_q           <= vs_in;
      de_q           <= de_in;
      hs_q           <= hs_in;
      rgb_q          <= rgb_d;
    end
  end

  assign next_ack     = next_ack_q;
  assign switch_pulse = switch_pulse_q;
  assign sel          = sel_q;
  assign de_out       = de_q;
  assign hs_out       = hs_q;
  assign vs_out       = vs_q;
  assign rgb_out      = rgb_q;

endmodule

// File: tb/tb_video_src_sched.sv
// Directed self-checking bench for video_src_sched with N_SRC=4, FRAMES_PER_SRC=3.
module tb_video_src_sched;

  logic        clk_pix;
  logic        rst_n;
  logic        de_in, hs_in, vs_in;
  logic [95:0] src_rgb;
  logic [3:0]  src_ready;
  logic        auto_en;
  logic        next_req;
  logic        next_ack;
  logic [1:0]  sel;
  logic        de_out, hs_out, vs_out;
  logic [23:0] rgb_out;
  logic        switch_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  video_src_sched #(.N_SRC(4), .FRAMES_PER_SRC(3)) dut (
    .clk_pix      (clk_pix),
    .rst_n        (rst_n),
    .de_in        (de_in),
    .hs_in        (hs_in),
    .vs_in        (vs_in),
    .src_rgb      (src_rgb),
    .src_ready    (src_ready),
    .auto_en      (auto_en),
    .next_req     (next_req),
    .next_ack     (next_ack),
    .sel          (sel),
    .de_out       (de_out),
    .hs_out       (hs_out),
    .vs_out       (vs_out),
    .rgb_out      (rgb_out),
    .switch_pulse (switch_pulse)
  );

  initial begin
    clk_pix = 1'b0;
    forever #5 clk_pix = ~clk_pix;
  end

  // Drive one cycle of timing; returns at posedge+1 with outputs reflecting these inputs.
  task automatic tick(input logic de, input logic hs, input logic vs);
    de_in = de; hs_in = hs; vs_in = vs;
    @(posedge clk_pix);
    #1;
  endtask

  // Miniature frame: 2 vsync lines, 2 active pixels, hsync, blank.
  task automatic run_frame(output int pulses, output int bad);
    logic [2:0] pat [6];
    pat[0] = 3'b001; pat[1] = 3'b001; pat[2] = 3'b100;
    pat[3] = 3'b100; pat[4] = 3'b010; pat[5] = 3'b000;
    pulses = 0; bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick(pat[i][2], pat[i][1], pat[i][0]);
      if (switch_pulse === 1'b1) begin
        pulses++;
        if (de_in === 1'b1) bad++;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    auto_en = 1'b0; next_req = 1'b0;
    src_ready = 4'b1111;
    src_rgb = {24'h404040, 24'hFF2020, 24'h00FF00, 24'h0000FF};
    repeat (2) @(posedge clk_pix);
    #1;
    n_tests++; if (sel !== 2'd0) begin n_fail++; $display("FAIL rst_sel got=%0d exp=0", sel); end
    n_tests++; if (next_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got=%b exp=0", next_ack); end
    n_tests++; if (switch_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_pulse got=%b exp=0", switch_pulse); end
    n_tests++; if ({de_out, hs_out, vs_out} !== 3'b000) begin n_fail++; $display("FAIL rst_timing got=%b exp=000", {de_out, hs_out, vs_out}); end
    n_tests++; if (rgb_out !== 24'h000000) begin n_fail++; $display("FAIL rst_rgb got=%h exp=000000", rgb_out); end
    rst_n = 1'b1;
  endtask

  task automatic test_auto_advance;
    int p, b;
    logic [1:0] exp_sel;
    auto_en = 1'b1;
    for (int f = 1; f <= 12; f++) begin
      run_frame(p, b);
      exp_sel = 2'((f / 3) % 4);
      n_tests++; if (sel !== exp_sel) begin n_fail++; $display("FAIL auto_sel frame=%0d got=%0d exp=%0d", f, sel, exp_sel); end
      n_tests++; if (p !== ((f % 3 == 0) ? 1 : 0)) begin n_fail++; $display("FAIL auto_pulses frame=%0d got=%0d exp=%0d", f, p, (f % 3 == 0) ? 1 : 0); end
      n_tests++; if (b !== 0) begin n_fail++; $display("FAIL auto_pulse_in_active frame=%0d got=%0d exp=0", f, b); end
    end
  endtask

  task automatic test_skip_not_ready;
    int p, b;
    src_ready = 4'b1001;
    run_frame(p, b); run_frame(p, b);
    n_tests++; if (sel !== 2'd0) begin n_fail++; $display("FAIL skip_hold got=%0d exp=0", sel); end
    run_frame(p, b);
    n_tests++; if (sel !== 2'd3) begin n_fail++; $display("FAIL skip_to3 got=%0d exp=3", sel); end
    repeat (3) run_frame(p, b);
    n_tests++; if (sel !== 2'd0) begin n_fail++; $display("FAIL skip_wrap got=%0d exp=0", sel); end
    src_ready = 4'b0001;
    run_frame(p, b); run_frame(p, b); run_frame(p, b);
    n_tests++; if (sel !== 2'd0) begin n_fail++; $display("FAIL none_ready_sel got=%0d exp=0", sel); end
    n_tests++; if (p !== 0) begin n_fail++; $display("FAIL none_ready_pulse got=%0d exp=0", p); end
    src_ready = 4'b1111;
    auto_en = 1'b0;
  endtask

  task automatic test_handshake;
    int p, b;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    next_req = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    n_tests++; if (next_ack !== 1'b0) begin n_fail++; $display("FAIL hs_ack_early got=%b exp=0", next_ack); end
    tick(1'b0, 1'b0, 1'b0);
    n_tests++; if (sel !== 2'd0) begin n_fail++; $display("FAIL hs_sel_before_fs got=%0d exp=0", sel); end
    tick(1'b0, 1'b0, 1'b1);
    n_tests++; if (sel !== 2'd1) begin n_fail++; $display("FAIL hs_sel_fs got=%0d exp=1", sel); end
    n_tests++; if (switch_pulse !== 1'b1) begin n_fail++; $display("FAIL hs_pulse got=%b exp=1", switch_pulse); end
    n_tests++; if (next_ack !== 1'b1) begin n_fail++; $display("FAIL hs_ack_rise got=%b exp=1", next_ack); end
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    n_tests++; if ({next_ack, switch_pulse} !== 2'b10) begin n_fail++; $display("FAIL hs_ack_hold got=%b exp=10", {next_ack, switch_pulse}); end
    next_req = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    n_tests++; if (next_ack !== 1'b0) begin n_fail++; $display("FAIL hs_ack_fall got=%b exp=0", next_ack); end
    run_frame(p, b);
    n_tests++; if (sel !== 2'd1) begin n_fail++; $display("FAIL hs_no_rearm got=%0d exp=1", sel); end
  endtask

  task automatic test_req_at_fs;
    next_req = 1'b1;
    tick(1'b0, 1'b0, 1'b1);
    n_tests++; if ({sel, switch_pulse, next_ack} !== {2'd1, 1'b0, 1'b0}) begin n_fail++; $display("FAIL reqfs_deferred got=%b exp=0100", {sel, switch_pulse, next_ack}); end
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    n_tests++; if (sel !== 2'd1) begin n_fail++; $display("FAIL reqfs_mid got=%0d exp=1", sel); end
    tick(1'b0, 1'b0, 1'b1);
    n_tests++; if ({sel, switch_pulse, next_ack} !== {2'd2, 1'b1, 1'b1}) begin n_fail++; $display("FAIL reqfs_switch got=%b exp=1011", {sel, switch_pulse, next_ack}); end
    next_req = 1'b0;
    tick(1'b0, 1'b0, 1'b1);
    n_tests++; if (next_ack !== 1'b0) begin n_fail++; $display("FAIL reqfs_ack_fall got=%b exp=0", next_ack); end
    tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_coincident;
    int p, b;
    auto_en = 1'b1;
    run_frame(p, b); run_frame(p, b);
    n_tests++; if (sel !== 2'd2) begin n_fail++; $display("FAIL coin_pre got=%0d exp=2", sel); end
    next_req = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    next_req = 1'b0;
    tick(1'b0, 1'b0, 1'b1);
    n_tests++; if (sel !== 2'd3) begin n_fail++; $display("FAIL coin_single_adv got=%0d exp=3", sel); end
    n_tests++; if (switch_pulse !== 1'b1) begin n_fail++; $display("FAIL coin_pulse got=%b exp=1", switch_pulse); end
    tick(1'b0, 1'b0, 1'b1);
    n_tests++; if ({next_ack, switch_pulse} !== 2'b00) begin n_fail++; $display("FAIL coin_after got=%b exp=00", {next_ack, switch_pulse}); end
    tick(1'b0, 1'b0, 1'b0);
    run_frame(p, b); run_frame(p, b);
    n_tests++; if (sel !== 2'd3) begin n_fail++; $display("FAIL coin_fcnt_clear got=%0d exp=3", sel); end
    run_frame(p, b);
    n_tests++; if (sel !== 2'd0) begin n_fail++; $display("FAIL coin_auto_resume got=%0d exp=0", sel); end
    auto_en = 1'b0;
  endtask

  task automatic test_datapath;
    src_ready = 4'b0100;
    next_req = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    next_req = 1'b0;
    tick(1'b0, 1'b0, 1'b1);
    n_tests++; if (sel !== 2'd2) begin n_fail++; $display("FAIL dp_sel got=%0d exp=2", sel); end
    n_tests++; if (vs_out !== 1'b1) begin n_fail++; $display("FAIL dp_vs_out got=%b exp=1", vs_out); end
    tick(1'b0, 1'b0, 1'b0);
    src_ready = 4'b1111;
    tick(1'b0, 1'b0, 1'b0);
    n_tests++; if (rgb_out !== 24'h000000) begin n_fail++; $display("FAIL dp_blank got=%h exp=000000", rgb_out); end
    tick(1'b1, 1'b0, 1'b0);
    n_tests++; if ({de_out, rgb_out} !== {1'b1, 24'hFF2020}) begin n_fail++; $display("FAIL dp_pixel got=%b/%h exp=1/ff2020", de_out, rgb_out); end
    tick(1'b0, 1'b1, 1'b0);
    n_tests++; if ({de_out, hs_out, rgb_out} !== {2'b01, 24'h000000}) begin n_fail++; $display("FAIL dp_de_low got=%b%b/%h exp=01/000000", de_out, hs_out, rgb_out); end
    src_ready = 4'b1011;
    tick(1'b1, 1'b0, 1'b0);
    n_tests++; if ({de_out, rgb_out} !== {1'b1, 24'h000000}) begin n_fail++; $display("FAIL dp_not_ready got=%b/%h exp=1/000000", de_out, rgb_out); end
    src_ready = 4'b1111;
    tick(1'b1, 1'b0, 1'b0);
    n_tests++; if (rgb_out !== 24'hFF2020) begin n_fail++; $display("FAIL dp_ready_again got=%h exp=ff2020", rgb_out); end
  endtask

  task automatic test_reset_mid_pend;
    int p, b;
    next_req = 1'b1;
    tick(1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (sel !== 2'd0) begin n_fail++; $display("FAIL rstp_sel got=%0d exp=0", sel); end
    n_tests++; if ({de_out, hs_out, vs_out, next_ack, switch_pulse} !== 5'b00000) begin n_fail++; $display("FAIL rstp_ctrl got=%b exp=00000", {de_out, hs_out, vs_out, next_ack, switch_pulse}); end
    n_tests++; if (rgb_out !== 24'h000000) begin n_fail++; $display("FAIL rstp_rgb got=%h exp=000000", rgb_out); end
    next_req = 1'b0;
    de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    @(posedge clk_pix);
    #1;
    rst_n = 1'b1;
    run_frame(p, b);
    n_tests++; if (sel !== 2'd0) begin n_fail++; $display("FAIL rstp_no_switch got=%0d exp=0", sel); end
    n_tests++; if (p !== 0) begin n_fail++; $display("FAIL rstp_no_pulse got=%0d exp=0", p); end
    n_tests++; if (next_ack !== 1'b0) begin n_fail++; $display("FAIL rstp_ack got=%b exp=0", next_ack); end
  endtask

  initial begin
    test_reset();
    test_auto_advance();
    test_skip_not_ready();
    test_handshake();
    test_req_at_fs();
    test_coincident();
    test_datapath();
    test_reset_mid_pend();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
